// File: rtl/ring_alloc_arbiter_if.sv
// Allocation/release bundle between requesters and the ring allocator.
// slave is the allocator side, master the requester/retire side.
interface ring_alloc_arbiter_if #(
    parameter int SIZE    = 32,
    parameter int REQ_NUM = 4
);
    localparam int PW = $clog2(SIZE);
    localparam int CW = $clog2(SIZE + 1);

    logic               i_clear;
    logic [REQ_NUM-1:0] i_req;
    logic [REQ_NUM-1:0] o_gnt;
    logic [PW-1:0]      o_alloc_ptr;
    logic               i_release;
    logic [PW-1:0]      o_release_ptr;
    logic [CW-1:0]      o_count;
    logic               o_full;
    logic               o_empty;
    logic               o_underflow;

    modport slave (
        input  i_clear, i_req, i_release,
        output o_gnt, o_alloc_ptr, o_release_ptr, o_count, o_full, o_empty, o_underflow
    );

    modport master (
        output i_clear, i_req, i_release,
        input  o_gnt, o_alloc_ptr, o_release_ptr, o_count, o_full, o_empty, o_underflow
    );
endinterface

// File: rtl/ring_alloc_arbiter.sv
// Round-robin allocator for a shared circular queue: grants one entry per cycle,
// retires entries in FIFO order and tracks occupancy, full/empty and underflow.
module ring_alloc_arbiter #(
    parameter int SIZE    = 32,
    parameter int REQ_NUM = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    ring_alloc_arbiter_if.slave bus
);
    localparam int PW = $clog2(SIZE);
    localparam int CW = $clog2(SIZE + 1);
    localparam int LW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    logic [PW-1:0]      r_in_ptr;
    logic [PW-1:0]      r_out_ptr;
    logic [CW-1:0]      r_count;
    logic [LW-1:0]      r_last;
    logic               r_underflow;

    logic               w_full;
    logic               w_empty;
    logic               w_alloc;
    logic               w_rel;
    logic               w_unf_evt;
    logic               w_found;
    logic [LW-1:0]      w_idx;
    logic [LW-1:0]      w_gnt_idx;
    logic [REQ_NUM-1:0] w_gnt;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(SIZE - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_full  = (r_count == CW'(SIZE));
    assign w_empty = (r_count == '0);

    // Search starts just past the last winner and ends on it.
    always_comb begin
        w_gnt     = '0;
        w_gnt_idx = r_last;
        w_found   = 1'b0;
        w_idx     = '0;
        if (!w_full && !bus.i_clear) begin
            for (int k = 1; k <= REQ_NUM; k++) begin
                w_idx = LW'((int'(r_last) + k) % REQ_NUM);
                if (!w_found && bus.i_req[w_idx]) begin
                    w_found      = 1'b1;
                    w_gnt_idx    = w_idx;
                    w_gnt[w_idx] = 1'b1;
                end
            end
        end
    end

    assign w_alloc   = w_found;
    assign w_rel     = bus.i_release && !w_empty && !bus.i_clear;
    assign w_unf_evt = bus.i_release && w_empty && !bus.i_clear;

    always_ff @(posedge i_clk) begin
        if (i_reset || bus.i_clear) begin
            r_in_ptr    <= '0;
            r_out_ptr   <= '0;
            r_count     <= '0;
            r_last      <= LW'(REQ_NUM - 1);
            r_underflow <= 1'b0;
        end else begin
            if (w_alloc) begin
                r_in_ptr <= f_inc(r_in_ptr);
                r_last   <= w_gnt_idx;
            end
            if (w_rel) begin
                r_out_ptr <= f_inc(r_out_ptr);
            end
            case ({w_alloc, w_rel})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_unf_evt) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.o_gnt         = w_gnt;
    assign bus.o_alloc_ptr   = r_in_ptr;
    assign bus.o_release_ptr = r_out_ptr;
    assign bus.o_count       = r_count;
    assign bus.o_full        = w_full;
    assign bus.o_empty       = w_empty;
    assign bus.o_underflow   = r_underflow;
endmodule

// File: doc/ring_alloc_arbiter.md
# ring_alloc_arbiter

Round-robin allocator that shares one circular-queue resource between several requesters. Each cycle it grants at most one requester a queue entry, hands out the entry index, and retires entries in FIFO order on release. It owns the queue's in/out pointers, occupancy count, full/empty status and flush. It sits in front of dispatch-side circular buffers, such as a shared load/store or issue queue, that are filled from multiple pipes.

## Interface
- SIZE, 32, number of queue entries; any value ≥ 2, not restricted to powers of two
- REQ_NUM, 4, number of requesters; ≥ 1
- PW, $clog2(SIZE), pointer width (derived)
- CW, $clog2(SIZE+1), count width (derived)

- i_clk  in  1  clock; single clock domain
- i_reset  in  1  reset; synchronous and active-high
- i_clear  in  1  flush: empties the queue and restarts arbitration
- i_req  in  REQ_NUM  per-requester allocation request (level)
- o_gnt  out  REQ_NUM  one-hot grant; the allocation takes effect this cycle
- o_alloc_ptr  out  PW  entry index given to the granted requester
- i_release  in  1  retire the oldest allocated entry
- o_release_ptr  out  PW  index of the oldest allocated entry
- o_count  out  CW  number of allocated entries
- o_full  out  1  o_count == SIZE
- o_empty  out  1  o_count == 0
- o_underflow  out  1  sticky: a release arrived while the queue was empty

## Operation
- State registers:
  - r_in_ptr and r_out_ptr (PW bits each)
  - r_count (CW bits)
  - r_last, the last granted index, log2 of REQ_NUM bits (minimum 1)
  - r_underflow
- Reset values: r_in_ptr=0, r_out_ptr=0, r_count=0, r_last=REQ_NUM-1, r_underflow=0.
  - Resulting outputs: o_gnt=0 whenever i_req=0, o_alloc_ptr=0, o_release_ptr=0, o_count=0, o_full=0, o_empty=1, o_underflow=0.
- Arbitration (combinational):
  - Search order starts at r_last+1, wraps modulo REQ_NUM, and ends at r_last.
  - The first index with i_req set is granted.
  - o_gnt=0 if o_full or i_clear is asserted.
- Allocate (alloc = |o_gnt):
  - r_in_ptr advances by 1; SIZE-1 wraps to 0.
  - r_last takes the granted index.
- Release (rel = i_release & !o_empty & !i_clear):
  - r_out_ptr advances by 1 with the same wrap rule.
- Count update:
  - alloc only: +1
  - rel only: −1
  - both: unchanged, but both pointers still advance
  - neither: hold
- Full gating: a release in a full cycle does not enable a grant in that same cycle. There is no bypass; the grant appears the next cycle.
- Underflow: i_release while o_empty and !i_clear is ignored (no pointer or count change) and sets r_underflow. r_underflow holds until reset or clear.
- Clear:
  - i_clear takes priority over everything except reset.
  - Next cycle: both pointers=0, count=0, r_last=REQ_NUM-1, r_underflow=0.
  - Any request or release in the clear cycle is dropped.
- Fairness: a continuously asserting requester is granted within REQ_NUM grant cycles. A requester that deasserts before being granted loses nothing; it keeps no state.
- REQ_NUM=1: arbitration degenerates to o_gnt = i_req & !o_full & !i_clear.

## Timing
- o_gnt and o_alloc_ptr are combinational from registers, i_req, i_clear and o_full. The requester samples o_alloc_ptr in the grant cycle.
- o_release_ptr, o_count, o_full, o_empty and o_underflow are pure register outputs. Their effect appears the cycle after the causing edge.
- Allocate-to-release latency: an entry allocated in cycle N is visible in o_count at N+1, and can be released at N+1 at the earliest.
- Reset asserted mid-operation: all state returns to reset values at the next edge, regardless of other inputs.
- Invariant: o_count == (r_in_ptr − r_out_ptr) mod SIZE, except when full (count SIZE, pointers equal).

## Test plan
- Reset, then i_req=4'b1111 held, with SIZE=32 and REQ_NUM=4:
  - grants rotate 0,1,2,3,0,…
  - o_alloc_ptr goes 0,1,2,…
  - o_count reaches 32 after 32 cycles, o_full=1, and o_gnt=0 thereafter.
- Full queue with i_release pulsed once and i_req held:
  - no grant in the release cycle
  - next cycle o_count=31 and a grant is issued with o_alloc_ptr=0 (wrap)
  - the following cycle o_count=32 again.
- Queue with count=5, simultaneous grant and release for 40 cycles:
  - o_count stays 5
  - both pointers wrap past 31 to 0
  - o_release_ptr trails o_alloc_ptr by 5 mod 32.
- SIZE=6 (non-power-of-2):
  - pointers wrap 5→0
  - full at count 6
  - o_count width is 3.
- i_release while empty:
  - o_underflow=1 next cycle, count stays 0, o_release_ptr unchanged
  - i_clear then drops o_underflow to 0.
- Mid-traffic with count=10, i_clear and i_req=4'b0100 in the same cycle:
  - o_gnt=0 in that cycle
  - next cycle count=0 and pointers=0
  - the following grant goes to requester 2 (search restarts at index 0).
